// File: rtl/pooled_pixel_streamer.sv
// pooled_pixel_streamer: captures a flattened pooled pixel matrix into a
// snapshot register and streams it out one pixel per beat over a
// valid/ready handshake, flagging the final beat and pulsing done afterwards.
//
// Optional build macro STREAMER_SKIP_ZERO_EN: zero-valued pixels are not
// presented, except the final index, which is always presented so last/done
// still occur. Skipped pixels cost no cycles.
//
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous active-low reset
//   start         request one frame (sampled only in IDLE)
//   input_pixels  flattened matrix, pixel p at [p*pixel_resolution +: pixel_resolution]
//   pixel_out     current pixel value
//   pixel_index   flattened index of pixel_out
//   pixel_valid   pixel_out/pixel_index/last valid
//   pixel_ready   consumer accepts the beat
//   last          current beat is the final beat of the frame
//   busy          high in SETTLE and STREAM
//   done          one-cycle pulse after the final transfer
module pooled_pixel_streamer #(
    parameter int unsigned pixel_resolution   = 8,
    parameter int unsigned matrix_side_length = 14,
    parameter int unsigned settle_cycles      = 1
) (
    input  logic                                                                   clk,
    input  logic                                                                   reset,
    input  logic                                                                   start,
    input  logic [pixel_resolution*matrix_side_length*matrix_side_length-1:0]      input_pixels,
    output logic [pixel_resolution-1:0]                                            pixel_out,
    output logic [$clog2(matrix_side_length*matrix_side_length)-1:0]               pixel_index,
    output logic                                                                   pixel_valid,
    input  logic                                                                   pixel_ready,
    output logic                                                                   last,
    output logic                                                                   busy,
    output logic                                                                   done
);

    localparam int unsigned PIX_N   = matrix_side_length * matrix_side_length;
    localparam int unsigned PIX_W   = pixel_resolution;
    localparam int unsigned IDX_W   = $clog2(PIX_N);
    localparam int unsigned FRAME_W = PIX_N * PIX_W;
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(PIX_N - 1);
    localparam logic [3:0]       SETTLE_LAST = 4'((settle_cycles == 0) ? 0 : settle_cycles - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t             state, state_n;
    logic [3:0]         settle_cnt, cnt_n;
    logic [FRAME_W-1:0] snapshot, snap_n;
    logic [IDX_W-1:0]   idx_n, cap_idx, adv_idx;
    logic [PIX_W-1:0]   pix_n;
    logic               valid_n, last_n, busy_n, done_n, capture;

    // Pixel at a given flattened index of a frame.
    function automatic logic [PIX_W-1:0] pick(input logic [FRAME_W-1:0] src,
                                              input logic [IDX_W-1:0]   idx);
        return src[int'(idx)*PIX_W +: PIX_W];
    endfunction

`ifdef STREAMER_SKIP_ZERO_EN
    // Lowest index >= from holding a nonzero pixel; the final index always qualifies.
    function automatic logic [IDX_W-1:0] seek(input logic [FRAME_W-1:0] src,
                                              input logic [IDX_W-1:0]   from);
        logic [IDX_W-1:0] res;
        res = LAST_IDX;
        for (int i = int'(PIX_N) - 2; i >= 0; i--) begin
            if (IDX_W'(i) >= from && src[i*PIX_W +: PIX_W] != '0) res = IDX_W'(i);
        end
        return res;
    endfunction

    assign cap_idx = seek(input_pixels, '0);
    assign adv_idx = seek(snapshot, pixel_index + IDX_W'(1));
`else
    assign cap_idx = '0;
    assign adv_idx = pixel_index + IDX_W'(1);
`endif

    // Next-state and next-output computation.
    always_comb begin
        state_n = state;
        cnt_n   = settle_cnt;
        snap_n  = snapshot;
        idx_n   = pixel_index;
        pix_n   = pixel_out;
        valid_n = pixel_valid;
        last_n  = last;
        done_n  = 1'b0;
        capture = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    if (settle_cycles == 0) begin
                        capture = 1'b1;
                    end else begin
                        state_n = SETTLE;
                        cnt_n   = '0;
                    end
                end
            end
            SETTLE: begin
                if (settle_cnt == SETTLE_LAST) capture = 1'b1;
                else                           cnt_n   = settle_cnt + 4'd1;
            end
            STREAM: begin
                if (pixel_ready) begin
                    if (last) begin
                        state_n = DONE;
                        valid_n = 1'b0;
                        last_n  = 1'b0;
                        idx_n   = '0;
                        pix_n   = '0;
                        done_n  = 1'b1;
                    end else begin
                        idx_n  = adv_idx;
                        pix_n  = pick(snapshot, adv_idx);
                        last_n = (adv_idx == LAST_IDX);
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Snapshot capture presents the first beat at the same edge.
        if (capture) begin
            state_n = STREAM;
            cnt_n   = '0;
            snap_n  = input_pixels;
            idx_n   = cap_idx;
            pix_n   = pick(input_pixels, cap_idx);
            valid_n = 1'b1;
            last_n  = (cap_idx == LAST_IDX);
        end

        busy_n = (state_n == SETTLE) || (state_n == STREAM);
    end

    // All state and outputs registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            settle_cnt  <= '0;
            snapshot    <= '0;
            pixel_index <= '0;
            pixel_out   <= '0;
            pixel_valid <= 1'b0;
            last        <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_n;
            settle_cnt  <= cnt_n;
            snapshot    <= snap_n;
            pixel_index <= idx_n;
            pixel_out   <= pix_n;
            pixel_valid <= valid_n;
            last        <= last_n;
            busy        <= busy_n;
            done        <= done_n;
        end
    end

endmodule

// File: tb/tb_pooled_pixel_streamer.sv
// Scoreboard bench for pooled_pixel_streamer (default parameters).
// Stimulus pushes expected beats into a queue; a monitor pops and compares
// on every transfer, and also checks output stability during stalls.
module tb_pooled_pixel_streamer;

    localparam int PIX_N = 196;
    localparam int W     = 8;
    localparam int TOT   = PIX_N * W;

    logic           clk;
    logic           reset;
    logic           start;
    logic [TOT-1:0] input_pixels;
    logic [W-1:0]   pixel_out;
    logic [7:0]     pixel_index;
    logic           pixel_valid;
    logic           pixel_ready;
    logic           last;
    logic           busy;
    logic           done;

    pooled_pixel_streamer dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .input_pixels (input_pixels),
        .pixel_out    (pixel_out),
        .pixel_index  (pixel_index),
        .pixel_valid  (pixel_valid),
        .pixel_ready  (pixel_ready),
        .last         (last),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] idx;
        logic [7:0] val;
        logic       lst;
    } beat_t;

    beat_t exp_q[$];
    int    checks   = 0;
    int    errors   = 0;
    int    done_cnt = 0;

    logic       prev_stall = 1'b0;
    logic [7:0] prev_idx, prev_val;
    logic       prev_last;

    // Monitor: scoreboard compare on transfers, hold check on stalls.
    always @(negedge clk) begin
        beat_t e;
        if (done) done_cnt++;
        if (prev_stall && pixel_valid) begin
            checks++;
            if (pixel_index !== prev_idx || pixel_out !== prev_val || last !== prev_last) begin
                errors++;
                $display("FAIL stall_hold: got idx=%0d val=%0h last=%0b required idx=%0d val=%0h last=%0b",
                         pixel_index, pixel_out, last, prev_idx, prev_val, prev_last);
            end
        end
        prev_stall = pixel_valid && !pixel_ready;
        prev_idx   = pixel_index;
        prev_val   = pixel_out;
        prev_last  = last;
        if (pixel_valid && pixel_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat: got idx=%0d val=%0h last=%0b, no beat expected",
                         pixel_index, pixel_out, last);
            end else begin
                e = exp_q.pop_front();
                if (pixel_index !== e.idx || pixel_out !== e.val || last !== e.lst) begin
                    errors++;
                    $display("FAIL beat: got idx=%0d val=%0h last=%0b required idx=%0d val=%0h last=%0b",
                             pixel_index, pixel_out, last, e.idx, e.val, e.lst);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, expv);
        end
    endtask

    // Reference model: which beats a frame produces.
    task automatic push_frame(input logic [TOT-1:0] pat);
        beat_t b;
        logic [7:0] v;
        for (int p = 0; p < PIX_N; p++) begin
            v = pat[p*W +: W];
`ifdef STREAMER_SKIP_ZERO_EN
            if (v == 8'h00 && p != PIX_N - 1) continue;
`endif
            b.idx = 8'(p);
            b.val = v;
            b.lst = (p == PIX_N - 1);
            exp_q.push_back(b);
        end
    endtask

    // Issue start at edge 0 and run until done (or abort); cycles = edges after edge 0.
    task automatic run_frame(input bit toggle, input bit corrupt, input bit poke,
                             input int abort_at, output int cycles);
        bit seen_done;
        seen_done = 1'b0;
        cycles    = 0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (k == 0) begin
                check("settle_busy", 32'(busy), 32'd1);
                check("settle_invalid", 32'(pixel_valid), 32'd0);
            end
            if (k == 1) check("first_valid", 32'(pixel_valid), 32'd1);
            if (done) begin
                seen_done = 1'b1;
                if (poke) start = 1'b1;
                break;
            end
            @(posedge clk);
            cycles++;
            #1;
            if (toggle) pixel_ready = ~pixel_ready;
            if (corrupt && cycles == 1) input_pixels = '1;
            if (poke && cycles == 60) start = 1'b1;
            if (poke && cycles == 61) start = 1'b0;
            if (abort_at > 0 && cycles == abort_at) begin
                #2 reset = 1'b0;
                #1 check("abort_outputs_zero",
                         32'({pixel_out, pixel_index, pixel_valid, last, busy, done}), 32'd0);
                exp_q.delete();
                return;
            end
        end
        if (!seen_done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done after %0d cycles, required done", cycles);
        end
        if (poke) begin
            @(posedge clk);
            #1 start = 1'b0;
        end
    endtask

    task automatic finish_checks(input string name, input int done_before);
        repeat (4) @(posedge clk);
        #1;
        check({name, "_done_count"}, 32'(done_cnt), 32'(done_before + 1));
        check({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
        check({name, "_idle_valid"}, 32'(pixel_valid), 32'd0);
        check({name, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    logic [TOT-1:0] ramp, sparse;
    int cyc, nb, d0;

    initial begin
        for (int p = 0; p < PIX_N; p++) ramp[p*W +: W] = 8'(p % 256);
        sparse = '0;
        sparse[3*W +: W]   = 8'h10;
        sparse[100*W +: W] = 8'h20;

        reset        = 1'b1;
        start        = 1'b0;
        pixel_ready  = 1'b1;
        input_pixels = ramp;
        #3 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("reset_outputs_zero",
                 32'({pixel_out, pixel_index, pixel_valid, last, busy, done}), 32'd0);
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;

        // Ramp frame, ready held high: no bubbles.
        d0 = done_cnt; push_frame(ramp); nb = exp_q.size();
        run_frame(1'b0, 1'b0, 1'b0, -1, cyc);
        check("ramp_cycles", 32'(cyc), 32'(nb + 1));
        finish_checks("ramp", d0);

        // Ready toggling every cycle.
        d0 = done_cnt; push_frame(ramp);
        run_frame(1'b1, 1'b0, 1'b0, -1, cyc);
        pixel_ready = 1'b1;
        finish_checks("toggle", d0);

        // Input overwritten right after capture.
        d0 = done_cnt; push_frame(ramp);
        run_frame(1'b0, 1'b1, 1'b0, -1, cyc);
        finish_checks("snapshot", d0);
        input_pixels = ramp;

        // Start pulses during STREAM and DONE are ignored.
        d0 = done_cnt; push_frame(ramp);
        run_frame(1'b0, 1'b0, 1'b1, -1, cyc);
        finish_checks("start_ignored", d0);

        // Asynchronous reset mid-stream, then a fresh frame.
        d0 = done_cnt; push_frame(ramp);
        run_frame(1'b0, 1'b0, 1'b0, 50, cyc);
        repeat (3) @(posedge clk);
        #1 check("abort_no_done", 32'(done_cnt), 32'(d0));
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;
        d0 = done_cnt; push_frame(ramp); nb = exp_q.size();
        run_frame(1'b0, 1'b0, 1'b0, -1, cyc);
        check("restart_cycles", 32'(cyc), 32'(nb + 1));
        finish_checks("restart", d0);

        // Sparse frame (mostly zeros).
        input_pixels = sparse;
        d0 = done_cnt; push_frame(sparse); nb = exp_q.size();
        run_frame(1'b0, 1'b0, 1'b0, -1, cyc);
        check("sparse_cycles", 32'(cyc), 32'(nb + 1));
        finish_checks("sparse", d0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pooled_pixel_streamer.md
POOLED_PIXEL_STREAMER -- requirements
Module: pooled_pixel_streamer

Interface
REQ-001 The block SHALL have parameter pixel_resolution, default 8: bits per pooled pixel.
REQ-002 The block SHALL have parameter matrix_side_length, default 14: side of the square pooled matrix; pixels_number = matrix_side_length**2.
REQ-003 The block SHALL have parameter settle_cycles, default 1, legal range 0..15: cycles waited after start before input_pixels is sampled, covering the registered pooling stage.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  request to stream one frame; sampled only in IDLE.
REQ-007 input_pixels  input  pixels_number*pixel_resolution  flattened pooled matrix, row-major, pixel p at bits [p*pixel_resolution +: pixel_resolution].
REQ-008 pixel_out  output  pixel_resolution  current pixel value.
REQ-009 pixel_index  output  $clog2(pixels_number)  flattened index of pixel_out.
REQ-010 pixel_valid  output  1  pixel_out/pixel_index valid.
REQ-011 pixel_ready  input  1  consumer accepts the beat.
REQ-012 last  output  1  current beat is the frame's final beat.
REQ-013 busy  output  1  high in SETTLE and STREAM.
REQ-014 done  output  1  one-cycle pulse after the final transfer.

Function
REQ-015 The FSM SHALL have states IDLE, SETTLE, STREAM, DONE.
REQ-016 IDLE with start=1 at an edge SHALL go to SETTLE, or directly to STREAM with snapshot capture at that edge when settle_cycles=0.
REQ-017 SETTLE SHALL count settle_cycles edges, then capture input_pixels into an internal snapshot register at the final counted edge and enter STREAM with pixel_index=0.
REQ-018 Streamed data SHALL come only from the snapshot; input_pixels changes during STREAM SHALL have no effect.
REQ-019 A transfer SHALL occur on an edge where pixel_valid=1 and pixel_ready=1; pixel_index then advances to the next presented index.
REQ-020 While pixel_valid=1 and pixel_ready=0, pixel_out, pixel_index and last SHALL hold stable.
REQ-021 pixel_valid SHALL be high for every STREAM cycle and low in all other states; pixel_valid SHALL not depend combinationally on pixel_ready.
REQ-022 last SHALL be high exactly when pixel_valid=1 and pixel_index=pixels_number-1.
REQ-023 The transfer with last=1 SHALL move STREAM to DONE; DONE SHALL assert done=1 for exactly one cycle, then return to IDLE.
REQ-024 start SHALL be ignored in SETTLE, STREAM and DONE; no queuing.
REQ-025 Sustained throughput SHALL be one beat per cycle with pixel_ready held high; frame of pixels_number beats has no bubbles.
REQ-026 pixel_out SHALL equal snapshot bits [pixel_index*pixel_resolution +: pixel_resolution], unmodified.

Reset
REQ-027 reset=0 SHALL immediately force IDLE, clear the snapshot, settle counter and index, and drive pixel_out=0, pixel_index=0, pixel_valid=0, last=0, busy=0, done=0.
REQ-028 Reset asserted mid-SETTLE or mid-STREAM SHALL abort the frame with no done pulse; the first rising edge after release SHALL be in IDLE.

Configuration
REQ-029 With macro STREAMER_SKIP_ZERO_EN defined, pixels of value 0 SHALL not be presented, except index pixels_number-1, which SHALL always be presented so last/done still occur; skipping SHALL add no idle cycles between nonzero beats.
REQ-030 Without STREAMER_SKIP_ZERO_EN, every index 0..pixels_number-1 SHALL be presented in ascending order.

Verification
REQ-031 Defaults, pixel p = p mod 256, pixel_ready=1, start pulse at edge 0 -> capture at edge 1, 196 consecutive beats with index=value 0..195, last on 195, done one cycle after.
REQ-032 pixel_ready toggled 0/1 each cycle, same frame -> 196 transfers, outputs stable during every stall, no index skipped or repeated.
REQ-033 input_pixels changed to all 0xFF immediately after capture -> streamed values still p mod 256.
REQ-034 start pulsed during STREAM and during DONE -> ignored, exactly one frame and one done pulse.
REQ-035 reset=0 asynchronously at beat 50 -> all outputs 0 at once, no done; new start after release streams from index 0.
REQ-036 STREAMER_SKIP_ZERO_EN, only indices 3 (0x10) and 100 (0x20) nonzero -> beats (3,0x10),(100,0x20),(195,0x00 with last=1), then done.
